// File: rtl/des_key_schedule.sv
// des_key_schedule: DES PC-1 plus per-round C||D rotation sequencer with ready/valid handshakes,
// emitting 16 states in encrypt (CD1..CD16) or decrypt (CD16..CD1) order.
module des_key_schedule (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] key_i,
  input  logic        decrypt_i,
  input  logic        key_valid_i,
  output logic        key_ready_o,
  output logic [55:0] cd_o,
  output logic        cd_valid_o,
  input  logic        cd_ready_i,
  output logic [3:0]  round_o,
  output logic        last_o
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                              10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                              63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                              14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  state_t      state_q, state_d;
  logic [55:0] cd_q, cd_d, pc1;
  logic [3:0]  round_q, round_d;
  logic        dec_q, dec_d, one;
  logic        unused_parity;
  for (genvar j = 0; j < 56; j++) begin : g_pc1
    assign pc1[j] = key_i[64-PC1[j]];
  end
  assign unused_parity = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                           key_i[24], key_i[16], key_i[8], key_i[0]};
  // cd bit 0 is DES bit 1, so a DES left rotate moves bits toward index 0.
  function automatic logic [27:0] rot(input logic [27:0] x, input logic right, input logic by1);
    return right ? (by1 ? {x[26:0], x[27]} : {x[25:0], x[27:26]})
                 : (by1 ? {x[0], x[27:1]}  : {x[1:0], x[27:2]});
  endfunction
  // Advancing into emitted rounds 1, 8 and 15 shifts by one in both directions.
  assign one = (round_q == 4'd0) || (round_q == 4'd7) || (round_q == 4'd14);
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    round_d = round_q;
    dec_d   = dec_q;
    if (state_q == IDLE && key_valid_i) begin
      state_d = RUN;
      dec_d   = decrypt_i;
      round_d = 4'd0;
      cd_d    = decrypt_i ? pc1 : {rot(pc1[55:28], 1'b0, 1'b1), rot(pc1[27:0], 1'b0, 1'b1)};
    end else if (state_q == RUN && cd_ready_i) begin
      state_d = (round_q == 4'd15) ? IDLE : RUN;
      round_d = (round_q == 4'd15) ? round_q : round_q + 4'd1;
      cd_d    = (round_q == 4'd15) ? cd_q
                                   : {rot(cd_q[55:28], dec_q, one), rot(cd_q[27:0], dec_q, one)};
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cd_q    <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      round_q <= round_d;
      dec_q   <= dec_d;
    end
  end
  assign key_ready_o = (state_q == IDLE);
  assign cd_valid_o  = (state_q == RUN);
  assign cd_o        = cd_q;
  assign round_o     = round_q;
  assign last_o      = (state_q == RUN) && (round_q == 4'd15);
endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: random-stimulus bench comparing the key schedule against a table-driven
// model of PC-1 and cumulative FIPS shifts, plus literal PC-2 subkeys for the reference key.
module tb_des_key_schedule;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [63:0] key_i = '0;
  logic        decrypt_i = 1'b0;
  logic        key_valid_i = 1'b0;
  logic        key_ready_o;
  logic [55:0] cd_o;
  logic        cd_valid_o;
  logic        cd_ready_i = 1'b0;
  logic [3:0]  round_o;
  logic        last_o;

  des_key_schedule dut (
    .clk_i(clk_i), .rst_i(rst_i), .key_i(key_i), .decrypt_i(decrypt_i),
    .key_valid_i(key_valid_i), .key_ready_o(key_ready_o), .cd_o(cd_o),
    .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .round_o(round_o), .last_o(last_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [63:0] REF_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] PAR_KEY = 64'h123456789ABCDEF0;
  localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                              10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                              63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                              14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                              23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                              41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                              44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SH [17] = '{0, 1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  int total = 0;
  int bad = 0;
  int lat;
  logic [55:0] s_cur [16];
  logic [55:0] s_enc [16];
  logic [63:0] nxt_key;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Beat r is DES round r+1 (encrypt) or 16-r (decrypt); C and D are CD0 advanced by the
  // cumulative left shift, so DES bit j of round k is CD0 bit ((j-1+s) mod 28)+1.
  function automatic logic [55:0] model_cd(input logic [63:0] key, input logic dec, input int r);
    logic [55:0] cd;
    int k = dec ? 16 - r : r + 1;
    int s = 0;
    for (int i = 1; i <= k; i++) s += SH[i];
    s = s % 28;
    for (int j = 0; j < 28; j++) begin
      cd[j]      = key[64 - PC1[(j + s) % 28]];
      cd[28 + j] = key[64 - PC1[28 + (j + s) % 28]];
    end
    return cd;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] k;
    for (int i = 0; i < 48; i++) k[47 - i] = cd[PC2[i] - 1];
    return k;
  endfunction

  logic        m_known = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_fresh = 1'b0;
  logic        m_dec = 1'b0;
  int          m_r = 0;
  logic [63:0] m_key = '0;

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_known <= 1'b1;
      m_busy  <= 1'b0;
      m_fresh <= 1'b1;
      m_r     <= 0;
    end else if (!m_busy && key_valid_i) begin
      m_busy  <= 1'b1;
      m_fresh <= 1'b0;
      m_r     <= 0;
      m_key   <= key_i;
      m_dec   <= decrypt_i;
    end else if (m_busy && cd_ready_i) begin
      if (m_r == 15) m_busy <= 1'b0;
      else m_r <= m_r + 1;
    end
  end

  always @(negedge clk_i) begin
    if (m_known) begin
      chk("key_ready", 64'(key_ready_o), 64'(!m_busy));
      chk("cd_valid", 64'(cd_valid_o), 64'(m_busy));
      chk("last", 64'(last_o), 64'(m_busy && m_r == 15));
      if (m_busy) begin
        chk("round", 64'(round_o), 64'(m_r));
        chk("cd", 64'(cd_o), 64'(model_cd(m_key, m_dec, m_r)));
      end else if (m_fresh) begin
        chk("idle_round", 64'(round_o), 64'd0);
        chk("idle_cd", 64'(cd_o), 64'd0);
      end
    end
  end

  // Offers a key, collects 16 beats into s_cur with random backpressure; hold keeps key_valid_i
  // high for the whole run with nxt_key presented once the first key is taken.
  task automatic run(input logic [63:0] key, input logic dec, input int stall_max, input bit hold);
    logic [55:0] h_cd;
    logic [3:0]  h_r;
    key_i = key;
    decrypt_i = dec;
    key_valid_i = 1'b1;
    lat = 0;
    do begin
      @(posedge clk_i); #1;
      lat++;
    end while (!cd_valid_o && lat < 20);
    if (!cd_valid_o) begin
      chk("accept_timeout", 64'(cd_valid_o), 64'd1);
      return;
    end
    key_valid_i = hold;
    key_i = hold ? nxt_key : {$urandom, $urandom};
    decrypt_i = ~dec;
    for (int b = 0; b < 16; b++) begin
      cd_ready_i = 1'b0;
      h_cd = cd_o;
      h_r = round_o;
      repeat ($urandom_range(0, stall_max)) begin
        @(posedge clk_i); #1;
        chk("stall_cd", 64'(cd_o), 64'(h_cd));
        chk("stall_round", 64'(round_o), 64'(h_r));
      end
      chk("beat_round", 64'(round_o), 64'(b));
      chk("beat_last", 64'(last_o), 64'(b == 15));
      s_cur[b] = cd_o;
      cd_ready_i = 1'b1;
      @(posedge clk_i); #1;
    end
    cd_ready_i = 1'b0;
    chk("end_valid", 64'(cd_valid_o), 64'd0);
    chk("end_ready", 64'(key_ready_o), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("rst_key_ready", 64'(key_ready_o), 64'd1);
    chk("rst_cd_valid", 64'(cd_valid_o), 64'd0);
    chk("rst_round", 64'(round_o), 64'd0);
    chk("rst_last", 64'(last_o), 64'd0);
    chk("model_k1", 64'(pc2(model_cd(REF_KEY, 1'b0, 0))), 64'h1B02EFFC7072);
    chk("model_k16", 64'(pc2(model_cd(REF_KEY, 1'b0, 15))), 64'hCB3D8B0E17F5);

    run(REF_KEY, 1'b0, 0, 1'b0);
    chk("enc_latency", 64'(lat), 64'd1);
    chk("enc_k1", 64'(pc2(s_cur[0])), 64'h1B02EFFC7072);
    chk("enc_k16", 64'(pc2(s_cur[15])), 64'hCB3D8B0E17F5);
    s_enc = s_cur;

    run(REF_KEY, 1'b1, 0, 1'b0);
    chk("dec_k16", 64'(pc2(s_cur[0])), 64'hCB3D8B0E17F5);
    chk("dec_k1", 64'(pc2(s_cur[15])), 64'h1B02EFFC7072);
    for (int i = 0; i < 16; i++) chk("dec_reversed", 64'(s_cur[i]), 64'(s_enc[15 - i]));

    for (int n = 0; n < 6; n++) begin
      nxt_key = {$urandom, $urandom};
      run({$urandom, $urandom}, 1'($urandom), 5, 1'b1);
      key_valid_i = 1'b0;
      @(posedge clk_i); #1;
    end

    key_i = {$urandom, $urandom};
    decrypt_i = 1'($urandom);
    key_valid_i = 1'b1;
    @(posedge clk_i); #1;
    key_valid_i = 1'b0;
    cd_ready_i = 1'b1;
    repeat (7) @(posedge clk_i);
    #1;
    chk("pre_abort_round", 64'(round_o), 64'd7);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    cd_ready_i = 1'b0;
    chk("abort_valid", 64'(cd_valid_o), 64'd0);
    chk("abort_ready", 64'(key_ready_o), 64'd1);
    chk("abort_round", 64'(round_o), 64'd0);
    run({$urandom, $urandom}, 1'($urandom), 2, 1'b0);

    nxt_key = PAR_KEY ^ 64'h0101010101010101;
    run(PAR_KEY, 1'b0, 0, 1'b1);
    s_enc = s_cur;
    run(PAR_KEY ^ 64'h0101010101010101, 1'b0, 0, 1'b0);
    chk("b2b_latency", 64'(lat), 64'd1);
    for (int i = 0; i < 16; i++) chk("parity_same", 64'(s_cur[i]), 64'(s_enc[i]));

    for (int n = 0; n < 4; n++) run({$urandom, $urandom}, 1'($urandom), 3, 1'b0);

    @(posedge clk_i); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
